mem_arbiter21: RTL and testbench

Two-requester arbiter sharing a single 32-bit memory port between instruction fetch (requester 0) and load/store (requester 1) in the multicycle core. It owns the select line of the 2:1 address/data multiplexing, grants the port round-robin, holds each transaction for a fixed memory latency, and returns read data with a one-cycle completion pulse. Address, write-enable and write data are registered, so the multiplexing is internal to this block.

---
 rtl/mem_arbiter21.sv | 137 +++++++++++++
 tb/tb_mem_arbiter21.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter21.sv
// ============================================================================
// Module   : mem_arbiter21
// Purpose  : Round-robin arbiter sharing one memory port between instruction
//            fetch (requester 0) and load/store (requester 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter21 #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] rdata,
    output logic        sel,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata_q,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata
);

    localparam logic [3:0] C_CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic [3:0]  r_cnt;
    logic        r_sel;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic [31:0] r_rdata_q;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_any;
    logic        w_win;

    // On contention the requester that was not served last wins.
    assign w_any = req0 | req1;
    assign w_win = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_cnt       <= 4'd0;
            r_sel       <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_rdata_q   <= 32'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel       <= w_win;
                        r_last      <= w_win;
                        r_gnt0      <= ~w_win;
                        r_gnt1      <= w_win;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= w_win ? addr1  : addr0;
                        r_mem_we    <= w_win ? we1    : we0;
                        r_mem_wdata <= w_win ? wdata1 : wdata0;
                        r_cnt       <= C_CNT_INIT;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Writes leave the last captured read data untouched.
                        if (!r_mem_we) begin
                            r_rdata_q <= rdata;
                        end
                        r_done0  <= ~r_sel;
                        r_done1  <= r_sel;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_gnt0   <= 1'b0;
                        r_gnt1   <= 1'b0;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign rdata_q   = r_rdata_q;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter21.sv
// ============================================================================
// Module   : tb_mem_arbiter21
// Purpose  : Directed self-checking bench for mem_arbiter21 (latency 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter21;

    logic        clk;
    logic        rst_n;
    logic        req0;
    logic        req1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        we0;
    logic        we1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] rdata;

    logic        sel, gnt0, gnt1, done0, done1, mem_en, mem_we;
    logic [31:0] rdata_q, mem_addr, mem_wdata;

    logic        sel_b, gnt0_b, gnt1_b, done0_b, done1_b, mem_en_b, mem_we_b;
    logic [31:0] rdata_q_b, mem_addr_b, mem_wdata_b;

    int total;
    int bad;

    mem_arbiter21 #(.MEM_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata(rdata),
        .sel(sel), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata_q(rdata_q), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    mem_arbiter21 #(.MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata(rdata),
        .sel(sel_b), .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
        .rdata_q(rdata_q_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        addr0  = 32'd0;
        addr1  = 32'd0;
        we0    = 1'b0;
        we1    = 1'b0;
        wdata0 = 32'd0;
        wdata1 = 32'd0;
        rdata  = 32'd0;
        #2;

        // Reset values
        chk("rst_sel",   {31'd0, sel},    32'd0);
        chk("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_done",  {30'd0, done1, done0}, 32'd0);
        chk("rst_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_addr",  mem_addr,  32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdq",   rdata_q,   32'd0);
        step();
        rst_n = 1'b1;

        // Single read by requester 0
        req0  = 1'b1;
        addr0 = 32'h0000_0010;
        we0   = 1'b0;
        rdata = 32'hAAAA_AAAA;
        step();
        chk("rd_sel",    {31'd0, sel},  32'd0);
        chk("rd_gnt0_a", {31'd0, gnt0}, 32'd1);
        chk("rd_gnt1_a", {31'd0, gnt1}, 32'd0);
        chk("rd_en",     {31'd0, mem_en}, 32'd1);
        chk("rd_addr",   mem_addr, 32'h0000_0010);
        step();
        chk("rd_gnt0_b", {31'd0, gnt0},  32'd1);
        chk("rd_done_b", {31'd0, done0}, 32'd0);
        step();
        chk("rd_done0",  {31'd0, done0}, 32'd1);
        chk("rd_done1",  {31'd0, done1}, 32'd0);
        chk("rd_gnt0_c", {31'd0, gnt0},  32'd0);
        chk("rd_en_off", {31'd0, mem_en}, 32'd0);
        chk("rd_rdq",    rdata_q, 32'hAAAA_AAAA);
        req0 = 1'b0;
        step();
        chk("rd_done_clr", {31'd0, done0}, 32'd0);

        // Write by requester 1
        req1   = 1'b1;
        addr1  = 32'h0000_0020;
        we1    = 1'b1;
        wdata1 = 32'h5555_5555;
        rdata  = 32'h1212_1212;
        step();
        chk("wr_sel",   {31'd0, sel},    32'd1);
        chk("wr_gnt1",  {31'd0, gnt1},   32'd1);
        chk("wr_we",    {31'd0, mem_we}, 32'd1);
        chk("wr_addr",  mem_addr,  32'h0000_0020);
        chk("wr_wdata", mem_wdata, 32'h5555_5555);
        step();
        step();
        chk("wr_done1", {31'd0, done1},  32'd1);
        chk("wr_done0", {31'd0, done0},  32'd0);
        chk("wr_rdq",   rdata_q, 32'hAAAA_AAAA);
        chk("wr_we_off", {31'd0, mem_we}, 32'd0);
        req1 = 1'b0;
        we1  = 1'b0;
        step();

        // Contention: both held, grants alternate 0,1,0,1 at 4-cycle spacing
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("ct%0d_sel", k),  {31'd0, sel},  32'(k % 2));
            chk($sformatf("ct%0d_gnt0", k), {31'd0, gnt0}, 32'((k % 2) == 0));
            chk($sformatf("ct%0d_gnt1", k), {31'd0, gnt1}, 32'((k % 2) == 1));
            step();
            step();
            chk($sformatf("ct%0d_done0", k), {31'd0, done0}, 32'((k % 2) == 0));
            chk($sformatf("ct%0d_done1", k), {31'd0, done1}, 32'((k % 2) == 1));
            step();
            chk($sformatf("ct%0d_idle", k), {30'd0, done1, done0}, 32'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Requester inputs change after the grant
        req0  = 1'b1;
        addr0 = 32'h1234_5678;
        step();
        chk("ic_addr_a", mem_addr, 32'h1234_5678);
        addr0 = 32'h8765_4321;
        req0  = 1'b0;
        step();
        chk("ic_addr_b", mem_addr, 32'h1234_5678);
        chk("ic_gnt0",   {31'd0, gnt0}, 32'd1);
        step();
        chk("ic_done0",  {31'd0, done0}, 32'd1);
        chk("ic_addr_c", mem_addr, 32'h1234_5678);
        step();

        // Reset mid-BUSY (last served was 0, so requester 1 is granted first)
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 32'h0000_0100;
        step();
        chk("mr_gnt1", {31'd0, gnt1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
        chk("mr_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        chk("mr_sel",   {31'd0, sel}, 32'd0);
        chk("mr_addr",  mem_addr, 32'd0);
        chk("mr_rdq",   rdata_q, 32'd0);
        step();
        chk("mr_nodone", {30'd0, done1, done0}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("mr_post_sel",  {31'd0, sel},  32'd0);
        chk("mr_post_gnt0", {31'd0, gnt0}, 32'd1);
        chk("mr_post_gnt1", {31'd0, gnt1}, 32'd0);
        step();
        step();
        chk("mr_post_done0", {31'd0, done0}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();

        // MEM_LATENCY = 1 instance
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0  = 1'b1;
        addr0 = 32'h0000_0040;
        we0   = 1'b0;
        rdata = 32'hFFFF_FFFF;
        step();
        chk("l1_gnt0", {31'd0, gnt0_b}, 32'd1);
        chk("l1_en",   {31'd0, mem_en_b}, 32'd1);
        step();
        chk("l1_done0", {31'd0, done0_b}, 32'd1);
        chk("l1_gnt_off", {31'd0, gnt0_b}, 32'd0);
        chk("l1_rdq",   rdata_q_b, 32'hFFFF_FFFF);
        req0 = 1'b0;
        step();
        chk("l1_done_clr", {31'd0, done0_b}, 32'd0);
        req0 = 1'b1;
        step();
        chk("l1_regrant", {31'd0, gnt0_b}, 32'd1);
        req0 = 1'b0;
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
